spi_flash_read_ctrl: RTL and testbench
======================================

# spi_flash_read_ctrl

Read-only SPI flash master that turns 32-bit word read requests into SPI flash transactions on the board-level flash pins (csb, sck, io0–io3). It sits between the SoC's flash/boot memory port and the external QSPI flash. It sequences command, address, mode, dummy and data phases, and keeps the flash in continuous-read (XIP) mode. After every reset it issues a mode-bit reset (MBR) so a flash left in XIP mode is recovered.

## Interface
- `CLK_DIV`, default 2: clk cycles per SCK half-period; legal range ≥1.
- `DUMMY_CYCLES`, default 8: SCK cycles between the mode byte and the first data nibble (quad only).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: read request.
- `req_ready` out 1: high only in IDLE.
- `req_addr` in 24: byte address; bits [1:0] ignored (treated as 0).
- `rsp_valid` out 1: one-cycle pulse; `rsp_data` valid.
- `rsp_data` out 32: `rsp_data[7:0]` is the byte at addr, `[15:8]` is addr+1, and so on (little-endian).
- `busy` out 1: high whenever the state is not IDLE.
- `flash_csb` out 1: chip select, active-low.
- `flash_sck` out 1: SPI clock, mode 0.
- `flash_io_out` out 4: pad output data.
- `flash_io_oe` out 4: pad output enables.
- `flash_io_in` in 4: pad input data.

## Operation
- States and transitions:
  - MBR → CSH → IDLE.
  - IDLE → CMD → ADDR → MODE → DUMMY → DATA → CSH → IDLE.
  - In XIP, IDLE goes directly to ADDR.
- **MBR:** csb low for 8 SCK cycles with io0=1 and oe=4'b0001, then csb high. Entered automatically after reset; no request is accepted until it completes.
- **CSH:** csb high, sck low, oe=0 for 2 SCK periods (4·CLK_DIV clk) before returning to IDLE.
- **CMD:** 0xEB, MSB first, on io0 only (oe=4'b0001), 8 SCK.
- **ADDR:** 24 bits, 4 lanes (io3..io0 = nibble, high nibble first), oe=4'b1111, 6 SCK.
- **MODE:** byte 0xA5 on 4 lanes, 2 SCK. On completion the internal `xip` flag is set.
- **DUMMY:** DUMMY_CYCLES SCK with oe=0.
- **DATA:** 8 SCK with oe=0. Nibbles are assembled high then low per byte, in address order.
- **XIP:** while `xip`=1, a request skips CMD and starts at ADDR with csb low.
- **SCK generation:**
  - Each SCK period is a low half then a high half, each CLK_DIV clk long; sck is low while csb is high.
  - Outputs change only at the clk edge that starts a low half.
  - `flash_io_in` is sampled at the clk edge that ends a high half, i.e. the edge where sck falls. The flash's rising-edge data is stable by then.
- **Address range:** any aligned address is legal. 0xFFFFFC reads bytes FFFFFC..FFFFFF; there is no wrap inside a word.
- **Handshake:**
  - A request is accepted when `req_valid && req_ready`. `req_addr` is captured then.
  - Exactly one `rsp_valid` pulse follows each accepted request, and the controller returns to IDLE only after CSH.
  - Requests are not pipelined.
- **Reset mid-transaction:**
  - On the cycle after `rst` is sampled high, `flash_csb`=1, sck=0, oe=0, `xip`=0, and no `rsp_valid` is generated.
  - After reset is released, the controller runs MBR then CSH before accepting requests.

## Timing
- Reset values: `req_ready`=0, `busy`=1 (MBR pending), `rsp_valid`=0, `rsp_data`=0, `flash_csb`=1, `flash_sck`=0, `flash_io_out`=0, `flash_io_oe`=0.
- Request accepted at cycle 0; csb falls at cycle 1.
- Let N be the number of SCK cycles in the transaction. The last sample is at cycle 1+2·CLK_DIV·N. `rsp_valid` and the csb rise occur at cycle 2+2·CLK_DIV·N.
- N values:
  - Quad, first request: 24+DUMMY_CYCLES (32 by default).
  - Quad, XIP: 16+DUMMY_CYCLES (24 by default).
  - Single-SPI: 64.
- `req_ready` rises 4·CLK_DIV cycles after `rsp_valid`.

## Configuration
- `SPI_FLASH_QUAD_EN` defined: quad 0xEB flow with XIP continuous mode, as above.
- `SPI_FLASH_QUAD_EN` undefined:
  - Single-lane 0x03 read: CMD 8 SCK, ADDR 24 SCK on io0, DATA 32 SCK sampled on io1.
  - oe=4'b0001 during CMD/ADDR and 0 during DATA.
  - No MODE/DUMMY states; `xip` is tied to 0.
  - MBR is still issued after reset.

## Test plan
- Reset, then idle with the flash model preloaded:
  - MBR shows exactly 8 SCK with io0=1 while csb is low.
  - `req_ready` rises only after CSH.
  - All outputs hold reset values during `rst`.
- Quad read of addr 0x100000 with memory bytes 11 22 33 44 → `rsp_data`=0x44332211. The flash sees cmd EB, addr 100000, mode A5, and `rsp_valid` arrives at cycle 2+4·32=130 (CLK_DIV=2).
- Second quad read of addr 0x100004 (bytes 55 66 77 88) → no CMD phase, `rsp_data`=0x88776655, `rsp_valid` at cycle 98.
- Read of addr 0xFFFFFE → the flash sees address FFFFFC, and `rsp_data` holds bytes FFFFFC..FFFFFF.
- `rst` asserted during DATA of an XIP read, then a new read issued → no `rsp_valid` for the aborted read. MBR follows, then a full EB command, and the data is correct.
- Build without `SPI_FLASH_QUAD_EN`, read addr 0x000010 (bytes DE AD BE EF) → cmd 03, `rsp_data`=0xEFBEADDE, `rsp_valid` at cycle 258.

Source files
------------

// File: rtl/spi_flash_read_ctrl.sv
// rtl/spi_flash_read_ctrl.sv - read-only SPI flash master: 32-bit word reads, XIP and mode-bit reset
// `define SPI_FLASH_QUAD_EN selects the quad 0xEB/XIP flow; otherwise single-lane 0x03 reads.
module spi_flash_read_ctrl #(
  parameter int CLK_DIV      = 2,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_sck,
  output logic [3:0]  flash_io_out,
  output logic [3:0]  flash_io_oe,
  input  logic [3:0]  flash_io_in
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CSH_W = $clog2(4 * CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CSH_W-1:0] CSH_LAST = CSH_W'(4 * CLK_DIV);
`ifdef SPI_FLASH_QUAD_EN
  localparam logic [7:0] CMD_BYTE = 8'hEB;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

  typedef enum logic [2:0] {
    S_MBR, S_CSH, S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA
  } state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [CSH_W-1:0]   csh_cnt;
  logic [7:0]         bit_cnt;
  logic               hi;
  logic               started;
  logic               rsp_pend;
  logic [23:0]        addr;
  logic [31:0]        shreg;
  logic               xip;
  logic               half_end;
  logic               sck_fall;
  logic               last_bit;

  function automatic logic [7:0] phase_len(state_t st);
    case (st)
`ifdef SPI_FLASH_QUAD_EN
      S_ADDR:  phase_len = 8'd6;
      S_MODE:  phase_len = 8'd2;
      S_DUMMY: phase_len = 8'(DUMMY_CYCLES);
      S_DATA:  phase_len = 8'd8;
`else
      S_ADDR:  phase_len = 8'd24;
      S_DATA:  phase_len = 8'd32;
`endif
      default: phase_len = 8'd8;
    endcase
  endfunction

  function automatic state_t phase_after(state_t st);
    case (st)
      S_CMD:   phase_after = S_ADDR;
`ifdef SPI_FLASH_QUAD_EN
      S_ADDR:  phase_after = S_MODE;
      S_MODE:  phase_after = (DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
      S_DUMMY: phase_after = S_DATA;
`else
      S_ADDR:  phase_after = S_DATA;
`endif
      default: phase_after = S_CSH;
    endcase
  endfunction

  // Pad pattern {oe, io} for SCK cycle idx of phase st.
  function automatic logic [7:0] pins(state_t st, logic [7:0] idx, logic [23:0] a);
    logic [23:0] sh;
    logic [7:0]  cmd;
    pins = 8'h00;
    cmd  = CMD_BYTE;
    case (st)
      S_MBR: pins = 8'h11;
      S_CMD: pins = {4'b0001, 3'b000, cmd[3'd7 - idx[2:0]]};
`ifdef SPI_FLASH_QUAD_EN
      S_ADDR: begin
        sh   = a << {idx[2:0], 2'b00};
        pins = {4'b1111, sh[23:20]};
      end
      S_MODE: pins = {4'b1111, idx[0] ? 4'h5 : 4'hA};
`else
      S_ADDR: begin
        sh   = a << idx[4:0];
        pins = {4'b0001, 3'b000, sh[23]};
      end
`endif
      default: pins = 8'h00;
    endcase
  endfunction

`ifndef SPI_FLASH_QUAD_EN
  assign xip = 1'b0;
  logic unused_in;
  assign unused_in = ^{flash_io_in[3:2], flash_io_in[0], req_addr[1:0]};
`else
  logic unused_in;
  assign unused_in = ^req_addr[1:0];
`endif

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign half_end  = (div_cnt == DIV_LAST);
  assign sck_fall  = started && hi && half_end;
  assign last_bit  = (bit_cnt == phase_len(state) - 8'd1);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_valid) state_next = xip ? S_ADDR : S_CMD;
      S_CSH:   if (csh_cnt == CSH_LAST) state_next = S_IDLE;
      default: if (sck_fall && last_bit) state_next = phase_after(state);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_MBR;
      div_cnt      <= '0;
      csh_cnt      <= '0;
      bit_cnt      <= '0;
      hi           <= 1'b0;
      started      <= 1'b0;
      rsp_pend     <= 1'b0;
      addr         <= '0;
      shreg        <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      flash_csb    <= 1'b1;
      flash_sck    <= 1'b0;
      flash_io_out <= '0;
      flash_io_oe  <= '0;
`ifdef SPI_FLASH_QUAD_EN
      xip          <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr     <= {req_addr[23:2], 2'b00};
            started  <= 1'b0;
            bit_cnt  <= '0;
            rsp_pend <= 1'b1;
          end
        end
        S_CSH: begin
          flash_csb                   <= 1'b1;
          flash_sck                   <= 1'b0;
          {flash_io_oe, flash_io_out} <= 8'h00;
          csh_cnt                     <= csh_cnt + 1'b1;
          // First CSH cycle is also the csb rising edge; the response goes out with it.
          if (csh_cnt == '0 && rsp_pend) begin
            rsp_valid <= 1'b1;
            rsp_data  <= {shreg[7:0], shreg[15:8], shreg[23:16], shreg[31:24]};
            rsp_pend  <= 1'b0;
          end
        end
        default: begin
          if (!started) begin
            started                     <= 1'b1;
            hi                          <= 1'b0;
            div_cnt                     <= '0;
            flash_csb                   <= 1'b0;
            flash_sck                   <= 1'b0;
            {flash_io_oe, flash_io_out} <= pins(state, 8'd0, addr);
          end else if (!half_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!hi) begin
              hi        <= 1'b1;
              flash_sck <= 1'b1;
            end else begin
              hi        <= 1'b0;
              flash_sck <= 1'b0;
              if (state == S_DATA) begin
`ifdef SPI_FLASH_QUAD_EN
                shreg <= {shreg[27:0], flash_io_in};
`else
                shreg <= {shreg[30:0], flash_io_in[1]};
`endif
              end
              if (last_bit) begin
                bit_cnt                     <= '0;
                csh_cnt                     <= '0;
                {flash_io_oe, flash_io_out} <= pins(state_next, 8'd0, addr);
`ifdef SPI_FLASH_QUAD_EN
                if (state == S_MODE) xip <= 1'b1;
`endif
              end else begin
                bit_cnt                     <= bit_cnt + 8'd1;
                {flash_io_oe, flash_io_out} <= pins(state, bit_cnt + 8'd1, addr);
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// tb/tb_spi_flash_read_ctrl.sv - randomized bench with a behavioural SPI/QSPI flash and word model
`timescale 1ns/1ps
module tb_spi_flash_read_ctrl;
  localparam int CLK_DIV = 2;
  localparam int DUMMY   = 8;
`ifdef SPI_FLASH_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif
  localparam int CMD_LEN  = 8;
  localparam int ADDR_LEN = QUAD ? 6 : 24;
  localparam int MODE_LEN = QUAD ? 2 : 0;
  localparam int DUM_LEN  = QUAD ? DUMMY : 0;
  localparam int DATA_LEN = QUAD ? 8 : 32;
  localparam logic [7:0] EXP_CMD = QUAD ? 8'hEB : 8'h03;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic        flash_csb;
  logic        flash_sck;
  logic [3:0]  flash_io_out;
  logic [3:0]  flash_io_oe;
  logic [3:0]  flash_io_in;

  spi_flash_read_ctrl #(.CLK_DIV(CLK_DIV), .DUMMY_CYCLES(DUMMY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .flash_csb(flash_csb), .flash_sck(flash_sck), .flash_io_out(flash_io_out),
    .flash_io_oe(flash_io_oe), .flash_io_in(flash_io_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [int];

  function automatic logic [7:0] mem_rd(logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[7:0] ^ a[23:16] ^ 8'h5A ^ {a[11:8], a[15:12]};
  endfunction

  function automatic logic [31:0] exp_word(logic [23:0] a);
    logic [23:0] b;
    b = {a[23:2], 2'b00};
    return {mem_rd(b + 24'd3), mem_rd(b + 24'd2), mem_rd(b + 24'd1), mem_rd(b)};
  endfunction

  task automatic preload(int a, logic [31:0] w);
    mem[a]     = w[7:0];
    mem[a + 1] = w[15:8];
    mem[a + 2] = w[23:16];
    mem[a + 3] = w[31:24];
  endtask

  // Flash model: decodes by rising-SCK position, drives read data at the rise.
  typedef struct {
    int          rises;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  mode;
    bit          skip_cmd;
    bit          io0_ones;
    bit          oe_mbr;
    int          oe_err;
  } xfer_t;

  xfer_t cur;
  xfer_t log_q[$];
  bit    flash_xip = 1'b0;

  always @(negedge flash_csb) begin
    cur.rises    = 0;
    cur.cmd      = '0;
    cur.addr     = '0;
    cur.mode     = '0;
    cur.skip_cmd = flash_xip;
    cur.io0_ones = 1'b1;
    cur.oe_mbr   = 1'b1;
    cur.oe_err   = 0;
  end

  always @(posedge flash_sck) begin
    if (flash_csb === 1'b0) begin
      logic [3:0] io;
      logic [3:0] exp_oe;
      logic [7:0] b;
      int p, off, k;
      io  = flash_io_out & flash_io_oe;
      p   = cur.rises;
      off = cur.skip_cmd ? 0 : CMD_LEN;
      cur.io0_ones = cur.io0_ones & io[0];
      cur.oe_mbr   = cur.oe_mbr & (flash_io_oe === 4'b0001);
      flash_io_in  = 4'($urandom);
      if (p < off) begin
        cur.cmd = {cur.cmd[6:0], io[0]};
        exp_oe  = 4'b0001;
      end else if (p < off + ADDR_LEN) begin
        cur.addr = QUAD ? {cur.addr[19:0], io} : {cur.addr[22:0], io[0]};
        exp_oe   = QUAD ? 4'b1111 : 4'b0001;
      end else if (p < off + ADDR_LEN + MODE_LEN) begin
        cur.mode = {cur.mode[3:0], io};
        exp_oe   = 4'b1111;
      end else begin
        exp_oe = 4'b0000;
        k = p - (off + ADDR_LEN + MODE_LEN + DUM_LEN);
        if (k >= 0 && k < DATA_LEN) begin
          if (QUAD) begin
            b = mem_rd(24'(cur.addr + 24'(k / 2)));
            flash_io_in = (k % 2 == 0) ? b[7:4] : b[3:0];
          end else begin
            b = mem_rd(24'(cur.addr + 24'(k / 8)));
            flash_io_in[1] = b[7 - (k % 8)];
          end
        end
      end
      if (flash_io_oe !== exp_oe) cur.oe_err++;
      cur.rises++;
    end
  end

  always @(posedge flash_csb) begin
    if (cur.rises > 0) begin
      log_q.push_back(cur);
      if (cur.rises == 8 && cur.io0_ones)
        flash_xip = 1'b0;
      else if (QUAD && cur.rises >= (cur.skip_cmd ? 0 : CMD_LEN) + ADDR_LEN + MODE_LEN)
        flash_xip = (cur.mode == 8'hA5);
    end
    cur.rises = 0;
  end

  bit exp_xip = 1'b0;

  task automatic release_and_mbr();
    int cyc, rise_cyc;
    bit fell;
    log_q.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    rise_cyc = -1;
    fell = 1'b0;
    while (!req_ready && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (rise_cyc < 0 && fell && flash_csb) rise_cyc = cyc;
      if (!flash_csb) fell = 1'b1;
    end
    check("mbr_csb_rise_cycle", rise_cyc, 2 + 16 * CLK_DIV);
    check("mbr_ready_cycle", cyc, 2 + 20 * CLK_DIV);
    check("mbr_xfer_count", log_q.size(), 1);
    if (log_q.size() > 0) begin
      check("mbr_sck_count", log_q[0].rises, 8);
      check("mbr_io0_high", log_q[0].io0_ones, 1);
      check("mbr_oe", log_q[0].oe_mbr, 1);
    end
    exp_xip = 1'b0;
  endtask

  task automatic do_read(logic [23:0] a, int abort_at);
    int n, cyc, j, extra;
    bit got;
    xfer_t t;
    n = exp_xip ? 16 + DUMMY : (QUAD ? 24 + DUMMY : 64);
    cyc = 0;
    while (!req_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_req", req_ready, 1);
    log_q.delete();
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk);
    #1;
    req_addr = 24'($urandom);
    cyc = 0;
    got = 1'b0;
    extra = 0;
    while (!got && cyc < 4000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
      if (abort_at >= 0 && cyc == abort_at && !got) begin
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_csb", flash_csb, 1);
        check("abort_sck", flash_sck, 0);
        check("abort_oe", flash_io_oe, 0);
        check("abort_busy", busy, 1);
        if (rsp_valid) extra++;
        repeat (3) begin
          @(negedge clk);
          if (rsp_valid) extra++;
        end
        check("abort_no_rsp", extra, 0);
        release_and_mbr();
        return;
      end
    end
    req_valid = 1'b0;
    check("rsp_seen", got, 1);
    check("rsp_cycle", cyc, 2 + 2 * CLK_DIV * n);
    check("rsp_data", rsp_data, exp_word(a));
    check("csb_at_rsp", flash_csb, 1);
    j = 0;
    while (!req_ready && j < 200) begin
      @(posedge clk);
      j++;
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    check("ready_after_rsp", j, 4 * CLK_DIV);
    check("single_rsp_pulse", extra, 0);
    check("xfer_count", log_q.size(), 1);
    if (log_q.size() > 0) begin
      t = log_q[0];
      check("sck_count", t.rises, n);
      check("flash_addr", t.addr, {a[23:2], 2'b00});
      check("oe_pattern", t.oe_err, 0);
      if (!exp_xip) check("flash_cmd", t.cmd, EXP_CMD);
      if (QUAD) check("flash_mode", t.mode, 8'hA5);
    end
    if (QUAD) exp_xip = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    flash_io_in = '0;
    preload(32'h100000, 32'h44332211);
    preload(32'h100004, 32'h88776655);
    preload(32'h000010, 32'hEFBEADDE);
    preload(32'hFFFFFC, 32'hC4C3C2C1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_csb", flash_csb, 1);
    check("rst_sck", flash_sck, 0);
    check("rst_io_out", flash_io_out, 0);
    check("rst_io_oe", flash_io_oe, 0);
    release_and_mbr();

    do_read(24'h100000, -1);
    do_read(24'h100004, -1);
    do_read(24'h000010, -1);
    do_read(24'hFFFFFE, -1);
    for (int i = 0; i < 6; i++) do_read(24'($urandom), -1);

    begin
      int n;
      n = exp_xip ? 16 + DUMMY : 64;
      do_read(24'($urandom), 1 + 2 * CLK_DIV * (n - 4) + 1);
    end
    do_read(24'h100000, -1);
    for (int i = 0; i < 3; i++) do_read(24'($urandom), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
